// File: rtl/pll_lock_supervisor.sv
// Lock supervisor for the board clock generator: pulses the DCM/PLL reset,
// waits for a stable lock window, then releases the downstream reset request.
module pll_lock_supervisor #(
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_W         = 20
) (
  input  logic       clk100_i,
  input  logic       async_rst_i,
  input  logic       dcm_locked_i,
  input  logic       pll_locked_i,
  input  logic       relock_req_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o
);

  // state       | meaning
  // RESET_PLL   | hold DCM/PLL in reset for RST_PULSE cycles
  // WAIT_LOCK   | wait for both locks, bounded by LOCK_TIMEOUT
  // STABILIZE   | locks must stay high for STABLE_CYCLES
  // RUN         | clocks good, downstream reset released
  // FAIL        | retries exhausted, clock generator held in reset
  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       retry;
  logic [3:0]       retry_nxt;
  logic [1:0]       dcm_sync;
  logic [1:0]       pll_sync;
  logic             lock;

  always_ff @(posedge clk100_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      dcm_sync <= 2'b00;
      pll_sync <= 2'b00;
    end else begin
      dcm_sync <= {dcm_sync[0], dcm_locked_i};
      pll_sync <= {pll_sync[0], pll_locked_i};
    end
  end

  assign lock = dcm_sync[1] & pll_sync[1];

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock) begin
          state_nxt = S_STABILIZE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry == RETRY_MAX) begin
            state_nxt = S_FAIL;
          end else begin
            state_nxt = S_RESET_PLL;
            retry_nxt = retry + 4'd1;
          end
        end
      end
      S_STABILIZE: begin
        if (!lock)                    state_nxt = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nxt = S_RUN;
      end
      S_RUN: begin
        // lock loss and relock request collapse into the same restart
        if (!lock || relock_req_i) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 4'd0;
        end
      end
      S_FAIL: begin
        if (relock_req_i) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = S_RESET_PLL;
        retry_nxt = 4'd0;
      end
    endcase
  end

  // Outputs decode state_nxt so they change on the same edge as the state.
  always_ff @(posedge clk100_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state       <= S_RESET_PLL;
      cnt         <= '0;
      retry       <= 4'd0;
      pll_rst_o   <= 1'b1;
      sys_rst_o   <= 1'b1;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
      retry_cnt_o <= 4'd0;
    end else begin
      state <= state_nxt;
      retry <= retry_nxt;
      // cnt may wrap in RUN/FAIL; neither state compares it
      if (state_nxt != state) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
      pll_rst_o   <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAIL);
      sys_rst_o   <= (state_nxt != S_RUN);
      ready_o     <= (state_nxt == S_RUN);
      fail_o      <= (state_nxt == S_FAIL);
      retry_cnt_o <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed test-plan scenarios plus randomized lock/relock traffic, each cycle
// compared against a phase/remaining-time reference model.
module tb_pll_lock_supervisor;
  localparam int RP = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FAIL = 4;

  logic       clk100 = 1'b0;
  logic       async_rst = 1'b1;
  logic       dcm = 1'b0;
  logic       pll = 1'b0;
  logic       relock = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [3:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: phase, cycles remaining in phase, retries used, lock history
  int ph, rem, tries;
  bit h1, h2;

  pll_lock_supervisor #(
    .RST_PULSE(RP), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR), .CNT_W(8)
  ) dut (
    .clk100_i(clk100),
    .async_rst_i(async_rst),
    .dcm_locked_i(dcm),
    .pll_locked_i(pll),
    .relock_req_i(relock),
    .pll_rst_o(pll_rst),
    .sys_rst_o(sys_rst),
    .ready_o(ready),
    .fail_o(fail),
    .retry_cnt_o(retry_cnt)
  );

  always #5 clk100 = ~clk100;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void enter(input int p);
    ph = p;
    case (p)
      P_RST:   rem = RP;
      P_WAIT:  rem = LT;
      P_STAB:  rem = SC;
      default: rem = 0;
    endcase
  endfunction

  function automatic void model_reset();
    enter(P_RST);
    tries = 0;
    h1 = 1'b0;
    h2 = 1'b0;
  endfunction

  function automatic void model_edge();
    bit lk;
    lk = h2;
    h2 = h1;
    h1 = dcm & pll;
    case (ph)
      P_RST: if (rem == 1) enter(P_WAIT); else rem--;
      P_WAIT: begin
        if (lk) enter(P_STAB);
        else if (rem == 1) begin
          if (tries == MR) enter(P_FAIL);
          else begin tries++; enter(P_RST); end
        end else rem--;
      end
      P_STAB: begin
        if (!lk) enter(P_WAIT);
        else if (rem == 1) enter(P_RUN);
        else rem--;
      end
      P_RUN:  if (!lk || relock) begin tries = 0; enter(P_RST); end
      default: if (relock) begin tries = 0; enter(P_RST); end
    endcase
  endfunction

  task automatic compare_all();
    check("pll_rst", 8'(pll_rst), 8'(ph == P_RST || ph == P_FAIL));
    check("sys_rst", 8'(sys_rst), 8'(ph != P_RUN));
    check("ready", 8'(ready), 8'(ph == P_RUN));
    check("fail", 8'(fail), 8'(ph == P_FAIL));
    check("retry_cnt", 8'(retry_cnt), 8'(tries));
  endtask

  task automatic step();
    @(posedge clk100);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk100);
    async_rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_imm_pll_rst", 8'(pll_rst), 8'd1);
    check("rst_imm_sys_rst", 8'(sys_rst), 8'd1);
    check("rst_imm_ready", 8'(ready), 8'd0);
    check("rst_imm_fail", 8'(fail), 8'd0);
    check("rst_imm_retry", 8'(retry_cnt), 8'd0);
    #3;
    @(negedge clk100);
    async_rst = 1'b0;
  endtask

  initial begin
    int mode;

    // 1: locks high from reset
    dcm = 1'b1; pll = 1'b1;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      step();
      check("s1_pll_rst", 8'(pll_rst), 8'(e < 4));
      check("s1_ready", 8'(ready), 8'(e >= 13));
      check("s1_sys_rst", 8'(sys_rst), 8'(e < 13));
      check("s1_retry", 8'(retry_cnt), 8'd0);
    end

    // 3: one-cycle PLL lock drop in RUN
    pll = 1'b0;
    step();
    pll = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 2) begin
        check("s3_ready_drop", 8'(ready), 8'd0);
        check("s3_pll_rst", 8'(pll_rst), 8'd1);
        check("s3_retry", 8'(retry_cnt), 8'd0);
      end
      if (k == 14) check("s3_ready_early", 8'(ready), 8'd0);
      if (k == 15) check("s3_ready_back", 8'(ready), 8'd1);
    end

    // 4: lock drop during STABILIZE
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      dcm = (e != 7);
      step();
      if (e >= 5 && e <= 17) begin
        check("s4_pll_rst", 8'(pll_rst), 8'd0);
        check("s4_ready", 8'(ready), 8'd0);
        check("s4_retry", 8'(retry_cnt), 8'd0);
      end
      if (e == 18) check("s4_ready_rise", 8'(ready), 8'd1);
    end
    dcm = 1'b1;

    // 2: locks low, exhaust retries
    dcm = 1'b0; pll = 1'b0;
    do_reset();
    for (int e = 1; e <= 115; e++) begin
      step();
      if (e == 36) check("s2_retry1", 8'(retry_cnt), 8'd1);
      if (e == 36 || e == 72) check("s2_pll_pulse", 8'(pll_rst), 8'd1);
      if (e == 40 || e == 76) check("s2_pll_low", 8'(pll_rst), 8'd0);
      if (e == 72) check("s2_retry2", 8'(retry_cnt), 8'd2);
      if (e == 107) check("s2_fail_early", 8'(fail), 8'd0);
      if (e >= 108) begin
        check("s2_fail", 8'(fail), 8'd1);
        check("s2_fail_pll", 8'(pll_rst), 8'd1);
      end
    end

    // 5: relock request from FAIL with locks high
    dcm = 1'b1; pll = 1'b1;
    repeat (5) step();
    relock = 1'b1;
    step();
    relock = 1'b0;
    check("s5_fail", 8'(fail), 8'd0);
    check("s5_retry", 8'(retry_cnt), 8'd0);
    check("s5_pll_rst", 8'(pll_rst), 8'd1);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 12) check("s5_ready_early", 8'(ready), 8'd0);
      if (k == 13) check("s5_ready", 8'(ready), 8'd1);
    end

    // 6: async reset mid-STABILIZE, then scenario-1 timing again
    do_reset();
    repeat (8) step();
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      step();
      check("s6_pll_rst", 8'(pll_rst), 8'(e < 4));
      check("s6_ready", 8'(ready), 8'(e >= 13));
    end

    // randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      mode = int'($urandom_range(0, 2));
      for (int c = 0; c < 200; c++) begin
        case (mode)
          0: begin
            dcm = ($urandom_range(0, 39) != 0);
            pll = ($urandom_range(0, 39) != 0);
          end
          1: begin
            dcm = 1'b0;
            pll = 1'($urandom_range(0, 1));
          end
          default: begin
            dcm = 1'($urandom_range(0, 1));
            pll = ($urandom_range(0, 3) != 0);
          end
        endcase
        relock = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 999) == 0) do_reset();
        step();
      end
    end
    relock = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
